// File: rtl/add_operand_stage_if.sv
// Handshake bundle for add_operand_stage: upstream operand channel plus the
// registered adder-input channel toward the result-capture stage.
interface add_operand_stage_if #(
   parameter int WIDTH = 64
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_din_one;
   logic [WIDTH-1:0] in_din_two;
   logic             in_cin;
   logic             in_sub;
   logic [WIDTH-1:0] din_one;
   logic [WIDTH-1:0] din_two;
   logic             cin;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  in_valid, in_din_one, in_din_two, in_cin, in_sub, out_ready,
      output in_ready, din_one, din_two, cin, out_valid
   );

   modport master (
      output in_valid, in_din_one, in_din_two, in_cin, in_sub, out_ready,
      input  in_ready, din_one, din_two, cin, out_valid
   );
endinterface

// File: rtl/add_operand_stage.sv
// Registered operand stage with a 2-entry skid buffer feeding adder_64bit.
// Optional macro ADD_OPERAND_STAGE_SUB_MODE_EN turns in_sub into A-B operand preparation.
module add_operand_stage #(
   parameter int WIDTH     = 64,
   parameter bit ZERO_IDLE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   add_operand_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             c;
   } opnd_t;

   localparam opnd_t OPND_ZERO = {(2*WIDTH+1){1'b0}};

   state_t state_q, state_d;
   opnd_t  main_q, main_d;
   opnd_t  skid_q, skid_d;
   logic   in_ready_q;
   logic   out_valid_q;

   opnd_t  in_opnd;
   opnd_t  main_idle;
   logic   in_xfer;
   logic   out_xfer;

   assign in_xfer  = bus.in_valid && in_ready_q;
   assign out_xfer = out_valid_q && bus.out_ready;

   // Shape the incoming pair before it is stored (subtract transform when enabled).
`ifdef ADD_OPERAND_STAGE_SUB_MODE_EN
   always_comb begin
      in_opnd.a = bus.in_din_one;
      if (bus.in_sub) begin
         in_opnd.b = ~bus.in_din_two;
         in_opnd.c = 1'b1;
      end else begin
         in_opnd.b = bus.in_din_two;
         in_opnd.c = bus.in_cin;
      end
   end
`else
   logic sub_unused;
   assign sub_unused = bus.in_sub;

   always_comb begin
      in_opnd.a = bus.in_din_one;
      in_opnd.b = bus.in_din_two;
      in_opnd.c = bus.in_cin;
   end
`endif

   // Value the main register takes when the stage drains to EMPTY.
   always_comb begin
      if (ZERO_IDLE) begin
         main_idle = OPND_ZERO;
      end else begin
         main_idle = main_q;
      end
   end

   // Next-state and buffer steering; flush overrides every transfer.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = main_idle;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_xfer) begin
                  state_d = S_ONE;
                  main_d  = in_opnd;
               end else begin
                  state_d = S_EMPTY;
               end
            end
            S_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_opnd;
               end else if (in_xfer) begin
                  state_d = S_TWO;
                  skid_d  = in_opnd;
               end else if (out_xfer) begin
                  state_d = S_EMPTY;
                  main_d  = main_idle;
               end else begin
                  state_d = S_ONE;
               end
            end
            S_TWO: begin
               if (out_xfer) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
               end else begin
                  state_d = S_TWO;
               end
            end
            default: begin
               state_d = S_EMPTY;
               main_d  = OPND_ZERO;
            end
         endcase
      end
   end

   // State, buffers and handshake flags; ready/valid are derived from next state so both stay registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         main_q      <= OPND_ZERO;
         skid_q      <= OPND_ZERO;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != S_TWO);
         out_valid_q <= (state_d != S_EMPTY);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.din_one   = main_q.a;
   assign bus.din_two   = main_q.b;
   assign bus.cin       = main_q.c;

endmodule

// File: tb/tb_add_operand_stage.sv
// Directed self-checking bench for add_operand_stage (ZERO_IDLE=1); expectations
// follow ADD_OPERAND_STAGE_SUB_MODE_EN when the macro is defined.
module tb_add_operand_stage;

   logic clk;
   logic rst;
   logic flush;
   int   n_total;
   int   n_pass;

   add_operand_stage_if #(.WIDTH(64)) bus ();

   add_operand_stage #(.WIDTH(64), .ZERO_IDLE(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic offer(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
      bus.in_valid   = 1'b1;
      bus.in_din_one = a;
      bus.in_din_two = b;
      bus.in_cin     = c;
      bus.in_sub     = s;
   endtask

   function automatic logic [64:0] adder(input logic [63:0] a, input logic [63:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {64'd0, c};
   endfunction

   initial begin
      logic [63:0] exp_b;
      logic        exp_c;
      logic [64:0] exp_sum;

      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_din_one = 64'd0;
      bus.in_din_two = 64'd0;
      bus.in_cin = 1'b0;
      bus.in_sub = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_din_one", bus.din_one, 64'd0);
      check("rst_din_two", bus.din_two, 64'd0);
      check("rst_cin", bus.cin, 1'b0);
      rst = 1'b0;
      tick();
      check("rel_in_ready", bus.in_ready, 1'b1);
      check("rel_out_valid", bus.out_valid, 1'b0);

      // Single pair, carry ripple across the 32-bit boundary
      offer(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      check("single_valid", bus.out_valid, 1'b1);
      check("single_a", bus.din_one, 64'h0000_0000_FFFF_FFFF);
      check("single_b", bus.din_two, 64'h1);
      check("single_cin", bus.cin, 1'b0);
      check("single_sum", adder(bus.din_one, bus.din_two, bus.cin), 65'h0_0000_0001_0000_0000);
      tick();
      check("single_drain", bus.out_valid, 1'b0);
      check("single_zero", bus.din_one, 64'd0);

      // Back-to-back stream at full throughput
      for (int i = 0; i < 8; i++) begin
         offer(64'(i), 64'(2 * i), i[0], 1'b0);
         tick();
         check("stream_ready", bus.in_ready, 1'b1);
         check("stream_valid", bus.out_valid, 1'b1);
         check("stream_a", bus.din_one, 64'(i));
         check("stream_b", bus.din_two, 64'(2 * i));
         check("stream_cin", bus.cin, i[0]);
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream_drain", bus.out_valid, 1'b0);

      // Backpressure: third pair waits for the skid to empty
      bus.out_ready = 1'b0;
      offer(64'h10, 64'h11, 1'b1, 1'b0);
      tick();
      check("bp0_valid", bus.out_valid, 1'b1);
      check("bp0_ready", bus.in_ready, 1'b1);
      check("bp0_a", bus.din_one, 64'h10);
      offer(64'h20, 64'h21, 1'b0, 1'b0);
      tick();
      check("bp1_ready", bus.in_ready, 1'b0);
      check("bp1_a_stable", bus.din_one, 64'h10);
      offer(64'h30, 64'h31, 1'b1, 1'b0);
      tick();
      check("bp2_ready", bus.in_ready, 1'b0);
      check("bp2_a_stable", bus.din_one, 64'h10);
      check("bp2_b_stable", bus.din_two, 64'h11);
      check("bp2_c_stable", bus.cin, 1'b1);
      bus.out_ready = 1'b1;
      tick();
      check("bp3_a", bus.din_one, 64'h20);
      check("bp3_b", bus.din_two, 64'h21);
      check("bp3_ready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("bp4_a", bus.din_one, 64'h30);
      check("bp4_cin", bus.cin, 1'b1);
      check("bp4_valid", bus.out_valid, 1'b1);
      tick();
      check("bp_drain", bus.out_valid, 1'b0);

      // Flush while full with a pair on offer
      bus.out_ready = 1'b0;
      offer(64'h40, 64'h41, 1'b1, 1'b0);
      tick();
      offer(64'h50, 64'h51, 1'b1, 1'b0);
      tick();
      check("fl_full", bus.in_ready, 1'b0);
      offer(64'h60, 64'h61, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("fl_valid", bus.out_valid, 1'b0);
      check("fl_ready", bus.in_ready, 1'b1);
      check("fl_a", bus.din_one, 64'd0);
      check("fl_b", bus.din_two, 64'd0);
      check("fl_cin", bus.cin, 1'b0);
      tick();
      tick();
      check("fl_no_ghost", bus.out_valid, 1'b0);

      // Reset mid-stream
      offer(64'h70, 64'h71, 1'b1, 1'b0);
      tick();
      check("mr_valid", bus.out_valid, 1'b1);
      offer(64'h80, 64'h81, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("mr_out_valid", bus.out_valid, 1'b0);
      check("mr_in_ready", bus.in_ready, 1'b0);
      check("mr_a", bus.din_one, 64'd0);
      check("mr_cin", bus.cin, 1'b0);
      tick();
      check("mr_ready_back", bus.in_ready, 1'b1);
      check("mr_idle", bus.out_valid, 1'b0);

      // Subtract request: A=5, B=7, in_cin=0
`ifdef ADD_OPERAND_STAGE_SUB_MODE_EN
      exp_b   = 64'hFFFF_FFFF_FFFF_FFF8;
      exp_c   = 1'b1;
      exp_sum = 65'h0_FFFF_FFFF_FFFF_FFFE;
`else
      exp_b   = 64'd7;
      exp_c   = 1'b0;
      exp_sum = 65'd12;
`endif
      offer(64'd5, 64'd7, 1'b0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_sub = 1'b0;
      check("sub_valid", bus.out_valid, 1'b1);
      check("sub_a", bus.din_one, 64'd5);
      check("sub_b", bus.din_two, exp_b);
      check("sub_cin", bus.cin, exp_c);
      check("sub_sum", adder(bus.din_one, bus.din_two, bus.cin), exp_sum);
      tick();
      check("sub_drain", bus.out_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
